// File: rtl/spu_pkg.sv
// Shared widths, opcode constants and the RF/FWD bundle layout for the SPU even pipe.
package spu_pkg;

    localparam int unsigned OP_W   = 11;
    localparam int unsigned FMT_W  = 3;
    localparam int unsigned ADDR_W = 7;
    localparam int unsigned IMM_W  = 18;
    localparam int unsigned QW     = 128;

    localparam logic [OP_W-1:0] OP_NOP = '0;

    typedef enum logic [FMT_W-1:0] {
        FMT_RR      = 3'd0,
        FMT_RRR     = 3'd1,
        FMT_RI7     = 3'd2,
        FMT_RI8     = 3'd3,
        FMT_RI10    = 3'd4,
        FMT_RI16    = 3'd5,
        FMT_RI18    = 3'd6,
        FMT_SPECIAL = 3'd7
    } format_e;

    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [FMT_W-1:0]  format;
        logic [ADDR_W-1:0] rt_addr;
        logic [QW-1:0]     ra;
        logic [QW-1:0]     rb;
        logic [IMM_W-1:0]  imm;
        logic              reg_write;
    } bundle_t;

endpackage

// File: rtl/spu_regfile.sv
// 2-read / 1-write quadword register file; a same-cycle write is visible on the read ports.
module spu_regfile
    import spu_pkg::*;
#(
    parameter int unsigned REG_COUNT = 128
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] ra_addr,
    input  logic [ADDR_W-1:0] rb_addr,
    output logic [QW-1:0]     ra_data,
    output logic [QW-1:0]     rb_data,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [QW-1:0]     wr_data
);

    logic [QW-1:0] mem [REG_COUNT];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < REG_COUNT; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        ra_data = (wr_en && (wr_addr == ra_addr)) ? wr_data : mem[ra_addr];
        rb_data = (wr_en && (wr_addr == rb_addr)) ? wr_data : mem[rb_addr];
    end

endmodule

// File: rtl/spu_operand_fetch.sv
// RF/FWD stage of the SPU even pipe: operand fetch with WB bypass, RAW stall
// against fixed-point results in flight, and the registered bundle for SimpleFixed1.
module spu_operand_fetch
    import spu_pkg::*;
#(
    parameter int unsigned EXEC_LAT  = 2,
    parameter int unsigned REG_COUNT = 128
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   in_op,
    input  logic [FMT_W-1:0]  in_format,
    input  logic [ADDR_W-1:0] in_rt_addr,
    input  logic [ADDR_W-1:0] in_ra_addr,
    input  logic [ADDR_W-1:0] in_rb_addr,
    input  logic              in_ra_used,
    input  logic              in_rb_used,
    input  logic [IMM_W-1:0]  in_imm,
    input  logic              in_reg_write,
    output logic [OP_W-1:0]   op,
    output logic [FMT_W-1:0]  format,
    output logic [ADDR_W-1:0] rt_addr,
    output logic [QW-1:0]     ra,
    output logic [QW-1:0]     rb,
    output logic [IMM_W-1:0]  imm,
    output logic              reg_write,
    input  logic [QW-1:0]     rt_wb,
    input  logic [ADDR_W-1:0] rt_addr_wb,
    input  logic              reg_write_wb,
    output logic [31:0]       stall_count
);

    logic [QW-1:0]     ra_data;
    logic [QW-1:0]     rb_data;
    logic              hazard;
    logic              accept;
    logic [ADDR_W-1:0] sb_addr [EXEC_LAT];
    logic              sb_wr   [EXEC_LAT];
    bundle_t           bundle_d;
    bundle_t           bundle_q;

    spu_regfile #(
        .REG_COUNT (REG_COUNT)
    ) u_regfile (
        .clk     (clk),
        .reset   (reset),
        .ra_addr (in_ra_addr),
        .rb_addr (in_rb_addr),
        .ra_data (ra_data),
        .rb_data (rb_data),
        .wr_en   (reg_write_wb),
        .wr_addr (rt_addr_wb),
        .wr_data (rt_wb)
    );

    // The WB bus itself is never compared: the regfile bypass already covers it.
    always_comb begin
        hazard = 1'b0;
        for (int unsigned k = 0; k < EXEC_LAT; k++) begin
            if (sb_wr[k] && ((in_ra_used && (sb_addr[k] == in_ra_addr)) ||
                             (in_rb_used && (sb_addr[k] == in_rb_addr)))) begin
                hazard = 1'b1;
            end
        end
        hazard = hazard & in_valid;
    end

    assign in_ready = ~hazard;
    assign accept   = in_valid & ~hazard;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned k = 0; k < EXEC_LAT; k++) begin
                sb_addr[k] <= '0;
                sb_wr[k]   <= 1'b0;
            end
        end else begin
            sb_addr[0] <= accept ? in_rt_addr : '0;
            sb_wr[0]   <= accept & in_reg_write;
            for (int unsigned k = 1; k < EXEC_LAT; k++) begin
                sb_addr[k] <= sb_addr[k-1];
                sb_wr[k]   <= sb_wr[k-1];
            end
        end
    end

    always_comb begin
        bundle_d = '0;
        bundle_d.op = OP_NOP;
        if (accept) begin
            bundle_d.op        = in_op;
            bundle_d.format    = in_format;
            bundle_d.rt_addr   = in_rt_addr;
            bundle_d.ra        = ra_data;
            bundle_d.rb        = rb_data;
            bundle_d.imm       = in_imm;
            bundle_d.reg_write = in_reg_write;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bundle_q <= '0;
        end else begin
            bundle_q <= bundle_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_count <= '0;
        end else if (hazard && (stall_count != '1)) begin
            stall_count <= stall_count + 32'd1;
        end
    end

    assign op        = bundle_q.op;
    assign format    = bundle_q.format;
    assign rt_addr   = bundle_q.rt_addr;
    assign ra        = bundle_q.ra;
    assign rb        = bundle_q.rb;
    assign imm       = bundle_q.imm;
    assign reg_write = bundle_q.reg_write;

endmodule

// File: tb/tb_spu_operand_fetch.sv
// Self-checking bench for spu_operand_fetch: directed scenarios then a random stream,
// checked against a timestamp-based hazard/operand model; the bench also plays the FU writeback.
module tb_spu_operand_fetch;

    localparam int unsigned L = 2;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [10:0]  in_op;
    logic [2:0]   in_format;
    logic [6:0]   in_rt_addr;
    logic [6:0]   in_ra_addr;
    logic [6:0]   in_rb_addr;
    logic         in_ra_used;
    logic         in_rb_used;
    logic [17:0]  in_imm;
    logic         in_reg_write;
    logic [10:0]  op;
    logic [2:0]   format;
    logic [6:0]   rt_addr;
    logic [127:0] ra;
    logic [127:0] rb;
    logic [17:0]  imm;
    logic         reg_write;
    logic [127:0] rt_wb;
    logic [6:0]   rt_addr_wb;
    logic         reg_write_wb;
    logic [31:0]  stall_count;

    always #5 clk = ~clk;

    spu_operand_fetch #(
        .EXEC_LAT  (L),
        .REG_COUNT (128)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_op        (in_op),
        .in_format    (in_format),
        .in_rt_addr   (in_rt_addr),
        .in_ra_addr   (in_ra_addr),
        .in_rb_addr   (in_rb_addr),
        .in_ra_used   (in_ra_used),
        .in_rb_used   (in_rb_used),
        .in_imm       (in_imm),
        .in_reg_write (in_reg_write),
        .op           (op),
        .format       (format),
        .rt_addr      (rt_addr),
        .ra           (ra),
        .rb           (rb),
        .imm          (imm),
        .reg_write    (reg_write),
        .rt_wb        (rt_wb),
        .rt_addr_wb   (rt_addr_wb),
        .reg_write_wb (reg_write_wb),
        .stall_count  (stall_count)
    );

    typedef struct {
        logic        v;
        logic [10:0] op;
        logic [2:0]  fmt;
        logic [6:0]  rt;
        logic [6:0]  ra;
        logic        rau;
        logic [6:0]  rb;
        logic        rbu;
        logic [17:0] imm;
        logic        rw;
    } ins_t;

    typedef struct {
        int         acc;
        logic [6:0] rt;
    } flight_t;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [127:0] m_rf [128];
    flight_t      flight [$];
    logic         sched_v [16];
    logic [6:0]   sched_a [16];
    logic [127:0] sched_d [16];
    logic [31:0]  m_stall;
    logic         ext_v;
    logic [6:0]   ext_a;
    logic [127:0] ext_d;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic ins_t mk(input logic v, input logic [10:0] o, input logic [2:0] f,
                                input logic [6:0] rt, input logic [6:0] a, input logic au,
                                input logic [6:0] b, input logic bu, input logic [17:0] im,
                                input logic rw);
        ins_t i;
        i.v = v; i.op = o; i.fmt = f; i.rt = rt; i.ra = a; i.rau = au;
        i.rb = b; i.rbu = bu; i.imm = im; i.rw = rw;
        return i;
    endfunction

    function automatic ins_t rand_ins();
        ins_t i;
        i.v   = ($urandom % 4) != 0;
        i.op  = 11'($urandom);
        i.fmt = 3'($urandom);
        i.rt  = 7'($urandom % 8);
        i.ra  = 7'($urandom % 8);
        i.rb  = 7'($urandom % 8);
        i.rau = 1'($urandom);
        i.rbu = 1'($urandom);
        i.imm = 18'($urandom);
        i.rw  = 1'($urandom);
        return i;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 128; i++) m_rf[i] = '0;
        for (int i = 0; i < 16; i++) sched_v[i] = 1'b0;
        flight.delete();
        m_stall = '0;
        ext_v   = 1'b0;
    endtask

    // One cycle: drive WB and decode, check in_ready, then check the bundle after the edge.
    task automatic step(input ins_t i, output logic acc);
        logic         hz, wv;
        logic [6:0]   wa;
        logic [127:0] wd, exp_ra, exp_rb;
        int           s, t;
        s = cyc % 16;
        if (sched_v[s]) begin
            wv = 1'b1; wa = sched_a[s]; wd = sched_d[s]; sched_v[s] = 1'b0;
        end else if (ext_v) begin
            wv = 1'b1; wa = ext_a; wd = ext_d;
        end else begin
            wv = 1'b0; wa = 7'($urandom); wd = {$urandom, $urandom, $urandom, $urandom};
        end
        ext_v = 1'b0;
        reg_write_wb = wv; rt_addr_wb = wa; rt_wb = wd;
        in_valid = i.v; in_op = i.op; in_format = i.fmt; in_rt_addr = i.rt;
        in_ra_addr = i.ra; in_rb_addr = i.rb; in_ra_used = i.rau; in_rb_used = i.rbu;
        in_imm = i.imm; in_reg_write = i.rw;
        #1;
        hz = 1'b0;
        foreach (flight[k]) begin
            if (cyc >= flight[k].acc + 1 && cyc <= flight[k].acc + int'(L) &&
                ((i.rau && flight[k].rt == i.ra) || (i.rbu && flight[k].rt == i.rb)))
                hz = 1'b1;
        end
        hz = hz & i.v;
        chk("in_ready", in_ready, !hz);
        acc = i.v && !hz;
        exp_ra = (wv && wa == i.ra) ? wd : m_rf[i.ra];
        exp_rb = (wv && wa == i.rb) ? wd : m_rf[i.rb];
        if (hz && m_stall != '1) m_stall++;
        if (acc && i.rw) begin
            t = (cyc + 1 + int'(L)) % 16;
            flight.push_back('{cyc, i.rt});
            sched_v[t] = 1'b1;
            sched_a[t] = i.rt;
            sched_d[t] = {$urandom, $urandom, $urandom, $urandom};
        end
        if (wv) m_rf[wa] = wd;
        @(posedge clk); #1;
        cyc++;
        chk("op",        op,        acc ? i.op  : 11'd0);
        chk("format",    format,    acc ? i.fmt : 3'd0);
        chk("rt_addr",   rt_addr,   acc ? i.rt  : 7'd0);
        chk("ra",        ra,        acc ? exp_ra : 128'd0);
        chk("rb",        rb,        acc ? exp_rb : 128'd0);
        chk("imm",       imm,       acc ? i.imm : 18'd0);
        chk("reg_write", reg_write, acc ? i.rw  : 1'b0);
        chk("stall_count", stall_count, m_stall);
        while (flight.size() > 0 && flight[0].acc + int'(L) < cyc) void'(flight.pop_front());
    endtask

    initial begin
        ins_t   idle, cur;
        logic   a, held;
        logic [127:0] ones16, fffe;
        idle   = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        ones16 = {8{16'h0001}};
        fffe   = {{127{1'b1}}, 1'b0};

        reset = 1'b1;
        in_valid = 0; in_op = 0; in_format = 0; in_rt_addr = 0; in_ra_addr = 0;
        in_rb_addr = 0; in_ra_used = 0; in_rb_used = 0; in_imm = 0; in_reg_write = 0;
        rt_wb = 0; rt_addr_wb = 0; reg_write_wb = 0;
        model_reset();
        #12;
        chk("rst_op", op, 11'd0);
        chk("rst_ra", ra, 128'd0);
        chk("rst_reg_write", reg_write, 1'b0);
        chk("rst_stall", stall_count, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Independent issue reading a value written over WB
        ext_v = 1'b1; ext_a = 7'd3; ext_d = ones16;
        step(idle, a);
        step(mk(1, 11'b01010110100, 3'd0, 7'd4, 7'd3, 1, 7'd0, 1, 18'd0, 1), a);
        chk("t1_issue", a, 1'b1);
        chk("t1_ra", ra, ones16);
        chk("t1_stall", stall_count, 32'd0);
        repeat (L + 1) step(idle, a);

        // RAW hazard: two stall cycles, then issue via WB bypass
        step(mk(1, 11'h011, 3'd0, 7'd5, 7'd1, 1, 7'd2, 1, 18'd0, 1), a);
        cur = mk(1, 11'h022, 3'd0, 7'd6, 7'd5, 1, 7'd0, 0, 18'd7, 1);
        step(cur, a); chk("t2_stall_a", a, 1'b0);
        step(cur, a); chk("t2_stall_b", a, 1'b0);
        step(cur, a); chk("t2_issue", a, 1'b1);
        chk("t2_count", stall_count, 32'd2);
        repeat (L + 1) step(idle, a);

        // Unused rb matching an in-flight destination does not stall
        step(mk(1, 11'h033, 3'd0, 7'd9, 7'd1, 1, 7'd2, 1, 18'd0, 1), a);
        step(mk(1, 11'h044, 3'd4, 7'd10, 7'd1, 1, 7'd9, 0, 18'h155, 1), a);
        chk("t3_issue", a, 1'b1);
        repeat (L + 1) step(idle, a);

        // Non-writing producer creates no hazard
        step(mk(1, 11'h055, 3'd0, 7'd5, 7'd1, 1, 7'd2, 1, 18'd0, 0), a);
        step(mk(1, 11'h066, 3'd0, 7'd11, 7'd5, 1, 7'd5, 1, 18'd0, 1), a);
        chk("t4_issue", a, 1'b1);
        repeat (L + 1) step(idle, a);

        // Same-cycle WB and read of $r7
        ext_v = 1'b1; ext_a = 7'd7; ext_d = fffe;
        step(mk(1, 11'h077, 3'd0, 7'd12, 7'd7, 1, 7'd7, 1, 18'd0, 0), a);
        chk("t5_ra", ra, fffe);
        chk("t5_rb", rb, fffe);
        step(mk(1, 11'h078, 3'd0, 7'd13, 7'd0, 0, 7'd7, 1, 18'd0, 0), a);
        chk("t5_rf", rb, fffe);
        repeat (L + 1) step(idle, a);

        // Reset in the middle of a stall
        step(mk(1, 11'h088, 3'd0, 7'd12, 7'd1, 1, 7'd2, 1, 18'd0, 1), a);
        cur = mk(1, 11'h099, 3'd0, 7'd14, 7'd12, 1, 7'd0, 0, 18'd3, 1);
        step(cur, a); chk("t6_stall", a, 1'b0);
        reset = 1'b1;
        #1;
        chk("t6_rst_op", op, 11'd0);
        chk("t6_rst_reg_write", reg_write, 1'b0);
        chk("t6_rst_stall", stall_count, 32'd0);
        model_reset();
        @(posedge clk); #1;
        cyc++;
        reset = 1'b0;
        step(cur, a);
        chk("t6_issue", a, 1'b1);
        chk("t6_ra", ra, 128'd0);
        chk("t6_count", stall_count, 32'd0);

        // Random stream on a small register window to provoke hazards
        held = 1'b0;
        cur  = idle;
        for (int n = 0; n < 400; n++) begin
            if (!held) cur = rand_ins();
            if (!held && ($urandom % 5) == 0) begin
                ext_v = 1'b1; ext_a = 7'($urandom % 8);
                ext_d = {$urandom, $urandom, $urandom, $urandom};
            end
            step(cur, a);
            held = cur.v && !a;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
